// File: rtl/twiddle_pkg.sv
// Shared configuration and FSM state type for the inverse twiddle generator.
package twiddle_pkg;

  localparam int unsigned TW_P_WIDTH  = 64;
  localparam int unsigned TW_PD_WIDTH = 128;
  localparam int unsigned TW_LANES    = 4;
  localparam int unsigned TW_GRP_LEN  = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN
  } tw_state_e;

endpackage

// File: rtl/mulmod_pipe_sync.sv
// Pipelined modular multiplier y = a * b mod n.
// Latency is STAGES clock-enabled beats: one product stage, one reduction
// stage, then pass-through stages. Operand b and modulus n are held constant
// by the caller for the duration of a group.
module mulmod_pipe_sync
  import twiddle_pkg::*;
#(
  parameter int unsigned P_WIDTH  = TW_P_WIDTH,
  parameter int unsigned PD_WIDTH = TW_PD_WIDTH,
  parameter int unsigned STAGES   = TW_LANES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  logic [P_WIDTH-1:0] a,
  input  logic [P_WIDTH-1:0] b,
  input  logic [P_WIDTH-1:0] n,
  output logic [P_WIDTH-1:0] y
);

  logic [PD_WIDTH-1:0] prod_q;
  logic [P_WIDTH-1:0]  res_q [STAGES-1];

  // Pipeline advances only on ce so that data alignment follows load events.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q <= '0;
      for (int unsigned i = 0; i < STAGES - 1; i++) begin
        res_q[i] <= '0;
      end
    end else if (ce) begin
      prod_q   <= PD_WIDTH'(a) * PD_WIDTH'(b);
      res_q[0] <= P_WIDTH'(prod_q % PD_WIDTH'(n));
      for (int unsigned i = 1; i < STAGES - 1; i++) begin
        res_q[i] <= res_q[i-1];
      end
    end
  end

  assign y = res_q[STAGES-2];

endmodule

// File: rtl/inv_twiddle_gen.sv
// Streaming inverse twiddle generator: per group emits LANES interleaved
// geometric sequences seed_j * w_inv^p mod N with ready/valid output.
// Optional feature macro: MODN_RANGE_CHECK_EN (adds sticky err_range output).
module inv_twiddle_gen
  import twiddle_pkg::*;
#(
  parameter int unsigned P_WIDTH  = TW_P_WIDTH,
  parameter int unsigned PD_WIDTH = TW_PD_WIDTH,
  parameter int unsigned LANES    = TW_LANES,
  parameter int unsigned GRP_LEN  = TW_GRP_LEN
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [P_WIDTH-1:0] w_inv_in,
  input  logic [P_WIDTH-1:0] N_in,
  input  logic [P_WIDTH-1:0] seed_in,
  input  logic               seed_valid,
  output logic               seed_ready,
  output logic [P_WIDTH-1:0] tw_out,
  output logic               tw_valid,
  input  logic               tw_ready,
  output logic               tw_last,
  output logic               busy
`ifdef MODN_RANGE_CHECK_EN
  ,
  output logic               err_range
`endif
);

  localparam int unsigned K_W = $clog2(GRP_LEN + 1);

  tw_state_e          state_q, state_d;
  logic [K_W-1:0]     k_q;
  logic [P_WIDTH-1:0] w_q, n_q, mul_y, load_data;
  logic               adv, load, start_acc, out_acc, last_load;

  assign adv       = !tw_valid || tw_ready;
  assign out_acc   = tw_valid && tw_ready;
  assign last_load = (k_q == K_W'(GRP_LEN - 1));
  assign busy      = (state_q != IDLE);

  // Next-state, load strobe and load data selection.
  always_comb begin
    state_d    = state_q;
    seed_ready = 1'b0;
    load       = 1'b0;
    load_data  = mul_y;
    start_acc  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        seed_ready = adv;
        load_data  = seed_in;
        if (seed_valid && adv) begin
          load = 1'b1;
          if (k_q == K_W'(LANES - 1)) state_d = RUN;
        end
      end
      RUN: begin
        if (adv) begin
          load = 1'b1;
          if (last_load) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_acc) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Output register, beat counter and per-group operand latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      tw_out   <= '0;
      tw_valid <= 1'b0;
      tw_last  <= 1'b0;
      k_q      <= '0;
      w_q      <= '0;
      n_q      <= '0;
    end else begin
      if (start_acc) begin
        w_q <= w_inv_in;
        n_q <= N_in;
        k_q <= '0;
      end
      if (load) begin
        tw_out   <= load_data;
        tw_valid <= 1'b1;
        tw_last  <= last_load;
        k_q      <= k_q + 1'b1;
      end else if (out_acc) begin
        tw_valid <= 1'b0;
        tw_last  <= 1'b0;
      end
    end
  end

  // Multiplier is fed with every word written to tw_out, so its result on
  // a RUN load is word[k-LANES] * w_inv, regardless of gaps or stalls.
  mulmod_pipe_sync #(
    .P_WIDTH (P_WIDTH),
    .PD_WIDTH(PD_WIDTH),
    .STAGES  (LANES)
  ) u_mul (
    .clk(clk),
    .rst(rst),
    .ce (load),
    .a  (load_data),
    .b  (w_q),
    .n  (n_q),
    .y  (mul_y)
  );

`ifdef MODN_RANGE_CHECK_EN
  // Sticky flag for out-of-range seed or inverse root; cleared by a new start.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_range <= 1'b0;
    end else if (start_acc) begin
      err_range <= (w_inv_in >= N_in);
    end else if (state_q == LOAD && load && seed_in >= n_q) begin
      err_range <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_inv_twiddle_gen.sv
// Self-checking bench for inv_twiddle_gen against a power-series model.
module tb_inv_twiddle_gen;

  localparam int L = 4;
  localparam int G = 16;

  logic        clk = 1'b0;
  logic        rst, start, seed_valid, seed_ready, tw_valid, tw_ready, tw_last, busy;
  logic [63:0] w_inv_in, N_in, seed_in, tw_out;
`ifdef MODN_RANGE_CHECK_EN
  logic        err_range;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inv_twiddle_gen #(
    .P_WIDTH (64),
    .PD_WIDTH(128),
    .LANES   (L),
    .GRP_LEN (G)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .w_inv_in  (w_inv_in),
    .N_in      (N_in),
    .seed_in   (seed_in),
    .seed_valid(seed_valid),
    .seed_ready(seed_ready),
    .tw_out    (tw_out),
    .tw_valid  (tw_valid),
    .tw_ready  (tw_ready),
    .tw_last   (tw_last),
    .busy      (busy)
`ifdef MODN_RANGE_CHECK_EN
    ,
    .err_range (err_range)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mulmod(input logic [63:0] a, input logic [63:0] b,
                                         input logic [63:0] n);
    logic [127:0] p;
    p = ({64'd0, a} * {64'd0, b}) % {64'd0, n};
    return p[63:0];
  endfunction

  // Word k = seed[k mod L] * w^(k div L) mod N.
  function automatic logic [63:0] ref_word(input logic [63:0] n, input logic [63:0] w,
                                           input logic [3:0][63:0] sd, input int k);
    logic [63:0] v;
    v = sd[k % L];
    for (int p = 0; p < k / L; p++) v = mulmod(v, w, n);
    return v;
  endfunction

  // One group: optional seed gap after the second seed, optional random
  // backpressure, optional abort via reset after abort_at accepted words.
  task automatic run_group(input logic [63:0] n, input logic [63:0] w,
                           input logic [3:0][63:0] sd, input int gap,
                           input bit rnd, input int abort_at);
    logic [63:0] expw [G];
    logic [63:0] held;
    int idx, sidx, gap_left, cyc, last_cyc;
    bit stalled;
    for (int k = 0; k < G; k++) expw[k] = ref_word(n, w, sd, k);
    idx = 0; sidx = 0; gap_left = 0; last_cyc = -1; stalled = 1'b0; held = '0;

    @(negedge clk);
    #1 chk("idle_before_start", {63'd0, busy}, 64'd0);
    start = 1'b1; w_inv_in = w; N_in = n; seed_valid = 1'b0; tw_ready = 1'b1;
    @(negedge clk);
    cyc = 1;
    while (idx < G && cyc < 400) begin
      tw_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start    = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      if (rnd) begin
        w_inv_in = {$urandom, $urandom};
        N_in     = {$urandom, $urandom};
      end
      if (gap_left > 0) begin
        seed_valid = 1'b0;
        gap_left--;
      end else begin
        seed_valid = (sidx < L);
      end
      seed_in = (sidx < L) ? sd[sidx] : {$urandom, $urandom};
      #1;
      if (stalled) begin
        chk("stall_valid", {63'd0, tw_valid}, 64'd1);
        chk("stall_data", tw_out, held);
      end
      if (seed_valid && seed_ready) begin
        sidx++;
        if (sidx == 2) gap_left = gap;
      end
      if (tw_valid && tw_ready) begin
        chk($sformatf("word%0d", idx), tw_out, expw[idx]);
        chk($sformatf("last%0d", idx), {63'd0, tw_last}, {63'd0, (idx == G - 1)});
        idx++;
        last_cyc = cyc;
        if (idx == abort_at) break;
      end
      stalled = tw_valid && !tw_ready;
      held    = tw_out;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; seed_valid = 1'b0; tw_ready = 1'b1;

    if (abort_at > 0) begin
      @(negedge clk);
      rst = 1'b1; start = 1'b1; seed_valid = 1'b1;
      @(negedge clk);
      rst = 1'b0; start = 1'b0; seed_valid = 1'b0;
      #1;
      chk("rst_valid", {63'd0, tw_valid}, 64'd0);
      chk("rst_last", {63'd0, tw_last}, 64'd0);
      chk("rst_out", tw_out, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_seed_ready", {63'd0, seed_ready}, 64'd0);
    end else begin
      chk("words_done", 64'(idx), 64'(G));
      if (!rnd) chk("last_accept_cycle", 64'(last_cyc), 64'(17 + gap));
      @(negedge clk);
      #1;
      chk("busy_after", {63'd0, busy}, 64'd0);
      chk("valid_after", {63'd0, tw_valid}, 64'd0);
    end
  endtask

  initial begin
    logic [3:0][63:0] sd;
    logic [63:0] n, w;

    rst = 1'b1; start = 1'b0; seed_valid = 1'b0; tw_ready = 1'b1;
    w_inv_in = '0; N_in = '0; seed_in = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_out", tw_out, 64'd0);
    chk("reset_valid", {63'd0, tw_valid}, 64'd0);
    chk("reset_last", {63'd0, tw_last}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_seed_ready", {63'd0, seed_ready}, 64'd0);
    rst = 1'b0;

    sd = {64'd7, 64'd5, 64'd3, 64'd1};
    run_group(64'd17, 64'd2, sd, 0, 1'b0, 0);
    run_group(64'd17, 64'd2, sd, 3, 1'b0, 0);
    run_group(64'd17, 64'd2, sd, 0, 1'b1, 0);

    n = 64'hFFFF_FFFF_0000_0001;
    chk("model_big_beat4", ref_word(n, n - 64'd1, {64'd4, 64'd3, 64'd2, 64'd1}, 4),
        64'hFFFF_FFFF_0000_0000);
    run_group(n, n - 64'd1, {64'd4, 64'd3, 64'd2, 64'd1}, 0, 1'b0, 0);

    run_group(64'd17, 64'd2, {64'd9, 64'd8, 64'd4, 64'd6}, 0, 1'b0, 9);
    run_group(64'd17, 64'd2, sd, 0, 1'b0, 0);

    for (int t = 0; t < 3; t++) begin
      n = {$urandom, $urandom} | 64'h8000_0000_0000_0001;
      w = {$urandom, $urandom} % n;
      for (int j = 0; j < L; j++) sd[j] = {$urandom, $urandom} % n;
      run_group(n, w, sd, int'($urandom_range(0, 4)), 1'b1, 0);
    end

`ifdef MODN_RANGE_CHECK_EN
    @(negedge clk);
    start = 1'b1; N_in = 64'd17; w_inv_in = 64'd2; tw_ready = 1'b1; seed_valid = 1'b0;
    @(negedge clk);
    start = 1'b0; seed_valid = 1'b1; seed_in = 64'd17;
    @(negedge clk);
    seed_in = 64'd1;
    #1 chk("err_set", {63'd0, err_range}, 64'd1);
    repeat (30) @(negedge clk);
    seed_valid = 1'b0;
    #1 chk("err_sticky", {63'd0, err_range}, 64'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; seed_valid = 1'b1;
    #1 chk("err_clear", {63'd0, err_range}, 64'd0);
    repeat (30) @(negedge clk);
    seed_valid = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inv_twiddle_gen.md
# inv_twiddle_gen

Streaming generator of inverse twiddle factors for the IFFT stages of the R16 NTT datapath: for each group it emits `LANES` interleaved geometric sequences `seed_j * w_inv^p mod N`, one word per accepted beat. Feedback-based twiddle generation runs in the inverse direction with a ready/valid output, so the IFFT butterfly stage can apply backpressure. Sits between the twiddle-seed ROM reader (upstream) and the IFFT butterfly multiplier (downstream).

## Interface
- `P_WIDTH`, 64, residue width
- `PD_WIDTH`, 128, full product width (2*P_WIDTH)
- `LANES`, 4, interleaved sequences; equals multiplier latency in load events
- `GRP_LEN`, 16, words per group; multiple of LANES, ≥ 2*LANES
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin group; sampled only in IDLE
- `w_inv_in`  in  P_WIDTH  inverse root; latched on accepted start
- `N_in`  in  P_WIDTH  modulus; latched on accepted start
- `seed_in`  in  P_WIDTH  lane seed, lane order 0..LANES-1
- `seed_valid`  in  1  seed word valid
- `seed_ready`  out  1  seed accepted when seed_valid && seed_ready
- `tw_out`  out  P_WIDTH  twiddle word (registered)
- `tw_valid`  out  1  tw_out valid
- `tw_ready`  in  1  consumer accepts when tw_valid && tw_ready
- `tw_last`  out  1  high with final word (beat GRP_LEN-1)
- `busy`  out  1  high in any state other than IDLE

## Operation
- States: IDLE → LOAD (start) → RUN (after LANES seeds loaded) → DRAIN (after beat GRP_LEN-1 loaded) → IDLE (last word accepted).
- adv = !tw_valid || tw_ready. A load event writes tw_out, sets tw_valid, increments beat counter `k`.
- LOAD: seed_ready = adv; each seed fire is a load event with tw_out ← seed_in.
- RUN: every cycle with adv is a load event; tw_out ← multiplier result, which is exactly `word[k-LANES] * w_inv mod N`.
- Multiplier input on each load event = value being written into tw_out; pipeline advances only on load events (ce = load), so alignment holds across seed gaps and output stalls.
- DRAIN: no loads; tw_valid drops after final accept.
- Output word k: lane k mod LANES, power k div LANES.
- Arithmetic: full PD_WIDTH product, reduced to [0, N). Seeds and w_inv must be < N; out-of-range input yields unspecified tw_out.
- start outside IDLE ignored; stale multiplier contents need no flush.

## Timing
- Reset: tw_out=0, tw_valid=0, tw_last=0, seed_ready=0, busy=0, k=0, state IDLE; mid-group reset aborts immediately, no partial flush; start in the reset cycle ignored.
- Seed fire at edge t → tw_out/tw_valid visible after edge t.
- Without stalls or seed gaps: start accepted at edge 0, seeds at edges 1..4, words at edges 1..16, busy falls after the edge accepting the last word.
- tw_valid held stable with tw_out constant while tw_ready low.
- Back-to-back groups: start in the cycle after return to IDLE.

## Configuration
- `MODN_RANGE_CHECK_EN` defined: extra output `err_range` (1 bit, reset 0) sets sticky when an accepted seed or latched w_inv is ≥ N; cleared on accepted start. Undefined: port and compare logic absent, behaviour otherwise identical.

## Structure
- Package `twiddle_pkg`: P_WIDTH/PD_WIDTH defaults, LANES, GRP_LEN, state enum (IDLE, LOAD, RUN, DRAIN).
- Sub-module `mulmod_pipe_sync`: LANES-stage pipelined modular multiplier, operand B constant (latched w_inv), clock enable, synchronous active-high reset.

## Test plan
- N=17, w_inv=2, seeds 1,3,5,7, tw_ready=1 → 1,3,5,7,2,6,10,14,4,12,3,11,8,7,6,5; tw_last on 16th word only.
- Same, seed_valid low for 3 cycles between seeds 2 and 3 → identical word sequence, no tw_valid bubbles beyond gaps.
- Same, tw_ready toggled pseudo-randomly → identical sequence, tw_out stable while stalled.
- N=0xFFFFFFFF00000001, w_inv=N-1, seeds 1,2,3,4 → powers alternate seed/N-seed; beat 4 word = 0xFFFFFFFF00000000.
- rst asserted at beat 9, then new group with fresh seeds → clean restart, output equals test 1 sequence.
- With MODN_RANGE_CHECK_EN: seed 17 with N=17 → err_range=1 until next accepted start.
